hazard_scoreboard: RTL and testbench

//  Consumer end of the execute-stage operand/destination interface: takes WriteRegE, PCBranchE
//  and control from the EX stage and returns forwarding selects, stall and flush to the pipeline.

---
 rtl/hazard_scoreboard.sv | 119 +++++++++++
 tb/tb_hazard_scoreboard.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// Execute-stage hazard unit: M/W forwarding selects, load-use stall and a
// branch-flush FSM that redirects the PC and bubbles D/E for FLUSH_CYCLES cycles.
module hazard_scoreboard #(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       RsD,
    input  logic [4:0]       RtD,
    input  logic [4:0]       RsE,
    input  logic [4:0]       RtE,
    input  logic [4:0]       WriteRegE,
    input  logic             RegWriteE,
    input  logic             MemtoRegE,
    input  logic             BranchTakenE,
    input  logic [31:0]      PCBranchE,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             StallF,
    output logic             StallD,
    output logic             FlushD,
    output logic             FlushE,
    output logic             PCRedirect,
    output logic [31:0]      PCRedirectTarget,
    output logic [CNT_W-1:0] StallCount,
    output logic [CNT_W-1:0] FlushCount
);

    typedef enum logic {RUN, FLUSH} state_t;

    localparam logic [2:0] FCNT_INIT = 3'(FLUSH_CYCLES - 1);

    state_t     state, state_nxt;
    logic [2:0] fcnt, fcnt_nxt;
    logic [4:0] WriteRegM, WriteRegW;
    logic       RegWriteM, RegWriteW;
    logic       lwstall;
    logic       take;

    // Register 0 is hardwired, so a write to it never produces a forward.
    function automatic logic [1:0] fwd_sel(input logic [4:0] src);
        if (RegWriteM && WriteRegM != 5'd0 && WriteRegM == src)
            return 2'b10;
        else if (RegWriteW && WriteRegW != 5'd0 && WriteRegW == src)
            return 2'b01;
        else
            return 2'b00;
    endfunction

    assign ForwardAE = fwd_sel(RsE);
    assign ForwardBE = fwd_sel(RtE);

    assign lwstall = MemtoRegE && RegWriteE && (WriteRegE != 5'd0) &&
                     ((WriteRegE == RsD) || (WriteRegE == RtD));

    always_comb begin
        state_nxt  = state;
        fcnt_nxt   = fcnt;
        StallF     = 1'b0;
        StallD     = 1'b0;
        FlushD     = 1'b0;
        FlushE     = 1'b0;
        PCRedirect = 1'b0;
        take       = 1'b0;
        unique case (state)
            RUN: begin
                if (BranchTakenE) begin
                    state_nxt = FLUSH;
                    fcnt_nxt  = FCNT_INIT;
                    take      = 1'b1;
                end else if (lwstall) begin
                    StallF = 1'b1;
                    StallD = 1'b1;
                    FlushE = 1'b1;
                end
            end
            FLUSH: begin
                FlushD     = 1'b1;
                FlushE     = 1'b1;
                // fcnt counts down from its load value, so the first cycle is the load value.
                PCRedirect = (fcnt == FCNT_INIT);
                if (fcnt == 3'd0)
                    state_nxt = RUN;
                else
                    fcnt_nxt = fcnt - 3'd1;
            end
            default: state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= RUN;
            fcnt             <= 3'd0;
            WriteRegM        <= 5'd0;
            WriteRegW        <= 5'd0;
            RegWriteM        <= 1'b0;
            RegWriteW        <= 1'b0;
            PCRedirectTarget <= 32'd0;
            StallCount       <= '0;
            FlushCount       <= '0;
        end else begin
            state     <= state_nxt;
            fcnt      <= fcnt_nxt;
            WriteRegM <= WriteRegE;
            RegWriteM <= RegWriteE && !FlushE;
            WriteRegW <= WriteRegM;
            RegWriteW <= RegWriteM;
            if (take) begin
                PCRedirectTarget <= PCBranchE;
                FlushCount       <= FlushCount + CNT_W'(1);
            end
            if (StallD)
                StallCount <= StallCount + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed scenarios plus random traffic, all
// checked against a cycle-level model of the hazard rules.
module tb_hazard_scoreboard;

    localparam int FC = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  RsD, RtD, RsE, RtE, WriteRegE;
    logic        RegWriteE, MemtoRegE, BranchTakenE;
    logic [31:0] PCBranchE;
    logic [1:0]  ForwardAE, ForwardBE;
    logic        StallF, StallD, FlushD, FlushE, PCRedirect;
    logic [31:0] PCRedirectTarget, StallCount, FlushCount;

    hazard_scoreboard #(.FLUSH_CYCLES(FC), .CNT_W(32)) dut (
        .clk(clk), .reset(reset),
        .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE), .WriteRegE(WriteRegE),
        .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .BranchTakenE(BranchTakenE),
        .PCBranchE(PCBranchE),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
        .PCRedirect(PCRedirect), .PCRedirectTarget(PCRedirectTarget),
        .StallCount(StallCount), .FlushCount(FlushCount)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    // Model state: the last two issued E instructions, remaining flush cycles, counters.
    logic        m_wr, w_wr;
    logic [4:0]  m_dst, w_dst;
    int          flush_left;
    logic [31:0] m_tgt, m_stall, m_flush;

    logic [1:0]   e_fa, e_fb;
    logic         e_stall, e_fd, e_fe, e_red;
    logic [104:0] exp_vec;
    wire  [104:0] act_vec = {ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE,
                             PCRedirect, PCRedirectTarget, StallCount, FlushCount};

    function automatic logic [1:0] src_sel(input logic [4:0] r);
        if (r == 0) return 2'b00;
        if (m_wr && m_dst == r) return 2'b10;
        if (w_wr && w_dst == r) return 2'b01;
        return 2'b00;
    endfunction

    task automatic predict();
        logic lw;
        logic in_fl;
        lw      = MemtoRegE && RegWriteE && WriteRegE != 0 && (WriteRegE == RsD || WriteRegE == RtD);
        in_fl   = flush_left > 0;
        e_stall = !in_fl && !BranchTakenE && lw;
        e_fd    = in_fl;
        e_fe    = in_fl || e_stall;
        e_red   = (flush_left == FC);
        e_fa    = src_sel(RsE);
        e_fb    = src_sel(RtE);
        exp_vec = {e_fa, e_fb, e_stall, e_stall, e_fd, e_fe, e_red, m_tgt, m_stall, m_flush};
    endtask

    task automatic tick();
        predict();
        @(posedge clk);
        if (reset) begin
            m_wr = 0; w_wr = 0; m_dst = 0; w_dst = 0;
            flush_left = 0; m_tgt = 0; m_stall = 0; m_flush = 0;
        end else begin
            w_wr  = m_wr;
            w_dst = m_dst;
            m_wr  = RegWriteE && !e_fe;
            m_dst = WriteRegE;
            if (flush_left > 0) flush_left--;
            else if (BranchTakenE) begin
                flush_left = FC;
                m_tgt      = PCBranchE;
                m_flush++;
            end
            if (e_stall) m_stall++;
        end
        #1;
    endtask

    task automatic drive(input logic [4:0] rsd, rtd, rse, rte, wre,
                         input logic rw, mr, bt, input logic [31:0] pcb);
        RsD = rsd; RtD = rtd; RsE = rse; RtE = rte; WriteRegE = wre;
        RegWriteE = rw; MemtoRegE = mr; BranchTakenE = bt; PCBranchE = pcb;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        predict();
        n_chk++;
        if (act_vec !== 105'd0) begin
            n_fail++; $display("FAIL reset_outputs got=%h want=0", act_vec);
        end
        n_chk++;
        if (act_vec !== exp_vec) begin
            n_fail++; $display("FAIL reset_model got=%h want=%h", act_vec, exp_vec);
        end
        tick();
    endtask

    task automatic test_forward();
        do_reset();
        drive(0, 0, 0, 0, 3, 1, 0, 0, 0);          // add r3 in E
        tick();
        drive(0, 0, 3, 0, 0, 0, 0, 0, 0);          // consumer of r3, one behind
        @(negedge clk); predict();
        n_chk++;
        if (ForwardAE !== 2'b10 || act_vec !== exp_vec) begin
            n_fail++; $display("FAIL fwd_from_m got=%b want=10 vec=%h exp=%h", ForwardAE, act_vec, exp_vec);
        end
        tick();
        @(negedge clk); predict();
        n_chk++;
        if (ForwardAE !== 2'b01 || act_vec !== exp_vec) begin
            n_fail++; $display("FAIL fwd_from_w got=%b want=01 vec=%h exp=%h", ForwardAE, act_vec, exp_vec);
        end
        tick();
        drive(0, 0, 0, 0, 0, 1, 0, 0, 0);          // write to r0
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk); predict();
        n_chk++;
        if (ForwardAE !== 2'b00 || act_vec !== exp_vec) begin
            n_fail++; $display("FAIL fwd_r0 got=%b want=00", ForwardAE);
        end
        tick();
        drive(0, 0, 0, 0, 5, 1, 0, 0, 0);
        tick();
        tick();                                    // r5 now in both M and W
        drive(0, 0, 0, 5, 0, 0, 0, 0, 0);
        @(negedge clk); predict();
        n_chk++;
        if (ForwardBE !== 2'b10 || act_vec !== exp_vec) begin
            n_fail++; $display("FAIL fwd_m_beats_w got=%b want=10", ForwardBE);
        end
        tick();
    endtask

    task automatic test_lwstall();
        do_reset();
        drive(0, 4, 0, 0, 4, 1, 1, 0, 0);
        @(negedge clk); predict();
        n_chk++;
        if ({StallF, StallD, FlushE} !== 3'b111 || act_vec !== exp_vec) begin
            n_fail++; $display("FAIL lwstall_assert got=%b want=111", {StallF, StallD, FlushE});
        end
        tick();
        drive(6, 6, 0, 0, 4, 1, 1, 0, 0);
        @(negedge clk); predict();
        n_chk++;
        if ({StallF, StallD, FlushE} !== 3'b000 || StallCount !== 32'd1 || act_vec !== exp_vec) begin
            n_fail++; $display("FAIL lwstall_nomatch stall=%b cnt=%0d want=000/1",
                               {StallF, StallD, FlushE}, StallCount);
        end
        tick();
    endtask

    task automatic test_branch();
        do_reset();
        drive(0, 0, 0, 0, 0, 0, 0, 1, 32'h40);
        @(negedge clk); predict();
        n_chk++;
        if ({PCRedirect, FlushD, FlushE} !== 3'b000 || act_vec !== exp_vec) begin
            n_fail++; $display("FAIL branch_n got=%b want=000", {PCRedirect, FlushD, FlushE});
        end
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk); predict();
        n_chk++;
        if ({PCRedirect, FlushD, FlushE} !== 3'b111 || PCRedirectTarget !== 32'h40 ||
            FlushCount !== 32'd1 || act_vec !== exp_vec) begin
            n_fail++; $display("FAIL branch_n1 got=%b tgt=%h cnt=%0d want=111/40/1",
                               {PCRedirect, FlushD, FlushE}, PCRedirectTarget, FlushCount);
        end
        tick();
        @(negedge clk); predict();
        n_chk++;
        if ({PCRedirect, FlushD, FlushE} !== 3'b011 || act_vec !== exp_vec) begin
            n_fail++; $display("FAIL branch_n2 got=%b want=011", {PCRedirect, FlushD, FlushE});
        end
        tick();
        @(negedge clk); predict();
        n_chk++;
        if ({PCRedirect, FlushD, FlushE} !== 3'b000 || act_vec !== exp_vec) begin
            n_fail++; $display("FAIL branch_n3 got=%b want=000", {PCRedirect, FlushD, FlushE});
        end
        tick();
    endtask

    task automatic test_branch_vs_lw();
        do_reset();
        drive(4, 0, 0, 0, 4, 1, 1, 1, 32'h80);
        @(negedge clk); predict();
        n_chk++;
        if ({StallF, StallD, FlushE} !== 3'b000 || act_vec !== exp_vec) begin
            n_fail++; $display("FAIL branch_prio got=%b want=000", {StallF, StallD, FlushE});
        end
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk); predict();
        n_chk++;
        if (FlushD !== 1'b1 || FlushCount !== 32'd1 || StallCount !== 32'd0 || act_vec !== exp_vec) begin
            n_fail++; $display("FAIL branch_prio_after fd=%b fcnt=%0d scnt=%0d want=1/1/0",
                               FlushD, FlushCount, StallCount);
        end
        tick();
        tick();
    endtask

    task automatic test_reset_mid_flush();
        do_reset();
        drive(0, 0, 0, 0, 0, 0, 0, 1, 32'h1234);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        @(negedge clk); predict();
        n_chk++;
        if (PCRedirect !== 1'b1 || act_vec !== exp_vec) begin
            n_fail++; $display("FAIL midflush_pre got=%b want=1", PCRedirect);
        end
        tick();
        reset = 1'b0;
        @(negedge clk); predict();
        n_chk++;
        if (act_vec !== 105'd0 || act_vec !== exp_vec) begin
            n_fail++; $display("FAIL midflush_reset got=%h want=0", act_vec);
        end
        tick();
        @(negedge clk); predict();
        n_chk++;
        if (act_vec !== 105'd0) begin
            n_fail++; $display("FAIL midflush_after got=%h want=0", act_vec);
        end
        tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 800; i++) begin
            reset = ($urandom_range(0, 79) == 0);
            drive(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  5'($urandom_range(0, 7)), 1'($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 7) == 0),
                  $urandom);
            @(negedge clk); predict();
            n_chk++;
            if (act_vec !== exp_vec) begin
                n_fail++; $display("FAIL random[%0d] got=%h want=%h", i, act_vec, exp_vec);
            end
            tick();
        end
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        m_wr = 0; w_wr = 0; m_dst = 0; w_dst = 0;
        flush_left = 0; m_tgt = 0; m_stall = 0; m_flush = 0;
        @(posedge clk); #1;
        test_reset();
        test_forward();
        test_lwstall();
        test_branch();
        test_branch_vs_lw();
        test_reset_mid_flush();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
